// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU family.
//   seq_op_e       : priority-resolved program-sequencer operation
//   DEFAULT_ADDR_W : default program address width
//   DEFAULT_STEP   : default bytes per instruction (PC increment)
package cpu_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_STEP   = 2;

    typedef enum logic [2:0] {
        SEQ_NEXT,
        SEQ_JUMP,
        SEQ_CALL,
        SEQ_RET,
        SEQ_HOLD
    } seq_op_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for the program sequencer.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears count only)
//   push       : write push_data on top (ignored when full)
//   pop        : drop top entry (ignored when empty); push has priority
//   push_data  : value to push
//   top_data   : current top entry (combinational read, valid when !empty)
//   count      : entries held
//   full/empty : registered, always consistent with count
module ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_reg, count_next;
    logic [CW-1:0]    count_m1;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;
    logic             do_push, do_pop;
    logic [IW-1:0]    wr_idx, top_idx;

    assign do_push  = push && !full_reg;
    assign do_pop   = pop && !push && !empty_reg;
    assign count_m1 = count_reg - CW'(1);
    assign wr_idx   = count_reg[IW-1:0];
    // When empty this index wraps; top_data is then don't-care.
    assign top_idx  = count_m1[IW-1:0];
    assign top_data = mem[top_idx];

    always_comb begin
        count_next = count_reg;
        if (do_push) begin
            count_next = count_reg + CW'(1);
        end else if (do_pop) begin
            count_next = count_m1;
        end
        full_next  = (count_next == CW'(DEPTH));
        empty_next = (count_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            count_reg <= count_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
        end
    end

    // Entry storage needs no reset: an entry is only read after it was pushed.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_idx == IW'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign count = count_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: registered fetch address with sequential advance,
// jump, call/return through an internal return stack, stall and sticky
// stack error flags.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   stall         : freeze pc, stack and error flags (err_clr ignored)
//   jump_en       : pc <= target_addr
//   call_en       : push pc+STEP, pc <= target_addr (overflow if full)
//   ret_en        : pc <= popped return address (underflow if empty)
//   target_addr   : jump/call destination
//   err_clr       : clear both sticky error flags
//   pc_out        : registered fetch address
//   stack_count   : entries on return stack
//   stack_full    : stack_count == STACK_DEPTH
//   stack_empty   : stack_count == 0
//   overflow_err  : sticky, call attempted while full
//   underflow_err : sticky, return attempted while empty
// Priority: stall > ret_en > call_en > jump_en > sequential.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = DEFAULT_ADDR_W,
    parameter int                STEP        = DEFAULT_STEP,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             jump_en,
    input  logic                             call_en,
    input  logic                             ret_en,
    input  logic [ADDR_W-1:0]                target_addr,
    input  logic                             err_clr,
    output logic [ADDR_W-1:0]                pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             overflow_err,
    output logic                             underflow_err
);

    seq_op_e          op;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] top_data;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;
    logic              push, pop;

    // Wraps modulo 2^ADDR_W; the pushed return address uses the same value.
    assign pc_inc = pc_reg + ADDR_W'(STEP);

    always_comb begin
        if (stall) begin
            op = SEQ_HOLD;
        end else if (ret_en) begin
            op = SEQ_RET;
        end else if (call_en) begin
            op = SEQ_CALL;
        end else if (jump_en) begin
            op = SEQ_JUMP;
        end else begin
            op = SEQ_NEXT;
        end
    end

    always_comb begin
        pc_next  = pc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        // Clear first so a coinciding set condition below wins.
        ovf_next = (err_clr && op != SEQ_HOLD) ? 1'b0 : ovf_reg;
        unf_next = (err_clr && op != SEQ_HOLD) ? 1'b0 : unf_reg;
        case (op)
            SEQ_HOLD: pc_next = pc_reg;
            SEQ_RET: begin
                if (stack_empty) begin
                    unf_next = 1'b1;
                end else begin
                    pc_next = top_data;
                    pop     = 1'b1;
                end
            end
            SEQ_CALL: begin
                if (stack_full) begin
                    ovf_next = 1'b1;
                end else begin
                    pc_next = target_addr;
                    push    = 1'b1;
                end
            end
            SEQ_JUMP: pc_next = target_addr;
            default:  pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg  <= RESET_ADDR;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .count     (stack_count),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign pc_out        = pc_reg;
    assign overflow_err  = ovf_reg;
    assign underflow_err = unf_reg;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-sequencing unit for the 8-bit CPU family, replacing the single-register PC. Generates the ROM fetch address and supports sequential advance, unconditional/conditional jump (condition resolved by the Controller), subroutine call and return via an internal LIFO return-address stack, and pipeline stall. Sits between the Controller (control strobes) and the instruction ROM address bus.

Parameters:
ADDR_W, 8, width of program address and all stack entries
STEP, 2, bytes per instruction; PC increment value
STACK_DEPTH, 4, number of return-address entries (≥1)
RESET_ADDR, 0, PC value loaded on reset

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC, stack and error flags this cycle
jump_en  in  1  load pc from target_addr (condition already resolved)
call_en  in  1  push pc+STEP, load pc from target_addr
ret_en  in  1  pop stack top into pc
target_addr  in  ADDR_W  jump/call destination (opcode2)
err_clr  in  1  clear sticky error flags
pc_out  out  ADDR_W  current fetch address (registered)
stack_count  out  $clog2(STACK_DEPTH+1)  entries currently held
stack_full  out  1  stack_count == STACK_DEPTH
stack_empty  out  1  stack_count == 0
overflow_err  out  1  sticky: call attempted while full
underflow_err  out  1  sticky: return attempted while empty

Behaviour:
- Reset (async assert, any time incl. mid-call): pc_out=RESET_ADDR, stack_count=0, stack_empty=1, stack_full=0, both error flags=0. Stack entry contents don't-care. First posedge after deassert performs normal update.
- pc_out is the registered PC; 1-cycle latency from strobe to new pc_out. No combinational path from inputs to pc_out.
- Per-posedge priority (highest first): stall > ret_en > call_en > jump_en > sequential.
  - stall=1: pc, stack, stack_count, error flags unchanged; err_clr ignored.
  - ret_en, stack non-empty: pc <= top entry; stack_count-1.
  - ret_en, stack empty: underflow_err <= 1; pc <= pc+STEP; count stays 0.
  - call_en, stack not full: push pc+STEP (return addr); pc <= target_addr; stack_count+1.
  - call_en, stack full: overflow_err <= 1; no push, no branch; pc <= pc+STEP.
  - jump_en: pc <= target_addr; stack untouched.
  - none: pc <= pc+STEP.
- Simultaneous ret_en & call_en: ret wins; call discarded, no error raised for it.
- Arithmetic: pc+STEP computed at ADDR_W bits, wraps modulo 2^ADDR_W (e.g. 8'hFE+2 -> 8'h00); return address wraps identically.
- Error flags: set per rules above; err_clr (when not stalled) clears both; if a set condition and err_clr coincide, set wins.
- Stack-pointer, full/empty are registered and consistent with stack_count every cycle.
- States (implicit via stack_count): EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH). Transitions only by successful push/pop; DEPTH=1 has no PARTIAL.

Decomposition:
- Shared package cpu_pkg: typedef seq_op_e {SEQ_NEXT, SEQ_JUMP, SEQ_CALL, SEQ_RET, SEQ_HOLD} for the priority-resolved operation; localparam defaults for ADDR_W and STEP reused by Controller/Datapath.
- One sub-module: ret_stack (parametrised LIFO, WIDTH=ADDR_W, DEPTH=STACK_DEPTH; push/pop/data/count/full/empty, async reset). pc_sequencer holds the PC register, priority decode and error flags.

Test Plan:
- Reset then 4 idle cycles -> pc_out 0x00,0x02,0x04,0x06,0x08; stack_empty=1, errors 0; assert reset mid-cycle -> pc_out 0x00 immediately, no clock.
- At pc=0x10 call_en, target 0x40; 2 idle; ret_en -> pc 0x40,0x42,0x44, then 0x12; stack_count 1 then 0.
- Four nested calls (targets 0x20,0x30,0x40,0x50) -> stack_full=1, count=4; fifth call at pc=0x52 -> overflow_err=1, pc=0x54, count stays 4; four returns unwind in LIFO order.
- ret_en with empty stack at pc=0x08 -> underflow_err=1, pc=0x0A; err_clr next cycle -> flag 0; err_clr coinciding with new underflow -> flag stays 1.
- stall held 3 cycles with jump_en=1, target 0x80 -> pc_out unchanged; release stall with jump_en -> pc=0x80; pc=0xFE sequential -> 0x00.
- call_en & ret_en together with count=1, top=0x22 -> pc=0x22, count=0, no overflow/underflow.
